fde_sequencer: RTL



---
 rtl/fde_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fde_sequencer.sv
// Fetch/Decode/Execute phase sequencer for the 8051 datapath: one-hot phase strobes,
// ready handshake, run/stop at instruction boundaries, watchdog/illegal-opcode trap, retire counter.
module fde_sequencer #(
    parameter int unsigned EXEC_TIMEOUT = 15,
    parameter int unsigned CNT_W        = 16,
    parameter logic [7:0]  ILLEGAL_OP   = 8'hA5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             ready,
    input  logic [7:0]       Opcode,
    output logic             Fetch,
    output logic             Decode,
    output logic             Execute,
    output logic             busy,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_TRAP    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_WDOG    = 2'b01,
        ERR_ILLEGAL = 2'b10
    } err_e;

    localparam logic [7:0]       TIMEOUT_C = 8'(EXEC_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [7:0]       exec_cnt_q, exec_cnt_d;
    err_e             err_code_q, err_code_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             fetch_q, fetch_d;
    logic             decode_q, decode_d;
    logic             execute_q, execute_d;
    logic             busy_q, busy_d;
    logic             error_q, error_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            exec_cnt_q    <= '0;
            err_code_q    <= ERR_NONE;
            instr_count_q <= '0;
            fetch_q       <= 1'b0;
            decode_q      <= 1'b0;
            execute_q     <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            exec_cnt_q    <= exec_cnt_d;
            err_code_q    <= err_code_d;
            instr_count_q <= instr_count_d;
            fetch_q       <= fetch_d;
            decode_q      <= decode_d;
            execute_q     <= execute_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        exec_cnt_d    = exec_cnt_q;
        err_code_d    = err_code_q;
        instr_count_d = instr_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (Opcode == ILLEGAL_OP) begin
                    state_d    = S_TRAP;
                    err_code_d = ERR_ILLEGAL;
                end else begin
                    state_d    = S_EXECUTE;
                    exec_cnt_d = '0;
                end
            end
            S_EXECUTE: begin
                if (exec_cnt_q != '1) exec_cnt_d = exec_cnt_q + 8'd1;
                // ready in the first execute cycle may be left over from the previous instruction
                if (ready && (exec_cnt_q != '0)) begin
                    instr_count_d = instr_count_q + CNT_ONE;
                    state_d       = run ? S_FETCH : S_IDLE;
                end else if (exec_cnt_q == TIMEOUT_C) begin
                    state_d    = S_TRAP;
                    err_code_d = ERR_WDOG;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies track state_q exactly.
    always_comb begin
        fetch_d   = (state_d == S_FETCH);
        decode_d  = (state_d == S_DECODE);
        execute_d = (state_d == S_EXECUTE);
        busy_d    = fetch_d | decode_d | execute_d;
        error_d   = (state_d == S_TRAP);
    end

    assign Fetch       = fetch_q;
    assign Decode      = decode_q;
    assign Execute     = execute_q;
    assign busy        = busy_q;
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign instr_count = instr_count_q;
    assign state       = state_q;

endmodule
